// File: rtl/ddr2_dfi_phy.sv
// rtl/ddr2_dfi_phy.sv - DDR2 DFI-to-pin PHY: registered command path, DQS-framed write burst, RD_LAT read capture
// Write timing: latch in N, preamble in N+1, data in N+2; read returns RD_LAT cycles after dfi_rddata_en.
module ddr2_dfi_phy #(
  parameter int CS_WIDTH   = 2,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DQ_WIDTH   = 64,
  parameter int RD_LAT     = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dfi_cke,
  input  logic [CS_WIDTH-1:0]       dfi_cs_n,
  input  logic                      dfi_ras_n,
  input  logic                      dfi_cas_n,
  input  logic                      dfi_we_n,
  input  logic [BA_WIDTH-1:0]       dfi_bank,
  input  logic [ADDR_WIDTH-1:0]     dfi_address,
  input  logic                      dfi_odt,
  input  logic                      dfi_wrdata_en,
  input  logic [2*DQ_WIDTH-1:0]     dfi_wrdata,
  input  logic [2*DQ_WIDTH/8-1:0]   dfi_wrdata_mask,
  input  logic                      dfi_rddata_en,
  output logic                      dfi_rddata_valid,
  output logic [2*DQ_WIDTH-1:0]     dfi_rddata,
  output logic                      ck,
  output logic                      ck_n,
  output logic                      cke,
  output logic [CS_WIDTH-1:0]       cs_n,
  output logic                      ras_n,
  output logic                      cas_n,
  output logic                      we_n,
  output logic [BA_WIDTH-1:0]       ba,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic                      odt,
  inout  wire  [DQ_WIDTH-1:0]       dq,
  inout  wire  [DQ_WIDTH/8-1:0]     dqs,
  inout  wire  [DQ_WIDTH/8-1:0]     dqs_n,
  inout  wire  [DQ_WIDTH/8-1:0]     dm_rdqs,
  inout  wire  [DQ_WIDTH/8-1:0]     rdqs_n
);

  localparam int NB = DQ_WIDTH / 8;

  assign ck   = clk;
  assign ck_n = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cke   <= 1'b0;
      cs_n  <= '1;
      ras_n <= 1'b1;
      cas_n <= 1'b1;
      we_n  <= 1'b1;
      ba    <= '0;
      addr  <= '0;
      odt   <= 1'b0;
    end else begin
      cke   <= dfi_cke;
      cs_n  <= dfi_cs_n;
      ras_n <= dfi_ras_n;
      cas_n <= dfi_cas_n;
      we_n  <= dfi_we_n;
      ba    <= dfi_bank;
      addr  <= dfi_address;
      odt   <= dfi_odt;
    end
  end

  // Stage 1 is the preamble cycle, stage 2 the data cycle, stage 3 marks the postamble.
  logic                    wr_v1, wr_v2, wr_v3;
  logic [2*DQ_WIDTH-1:0]   wr_d1, wr_d2;
  logic [2*NB-1:0]         wr_m1, wr_m2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_v1 <= 1'b0;
      wr_v2 <= 1'b0;
      wr_v3 <= 1'b0;
      wr_d1 <= '0;
      wr_d2 <= '0;
      wr_m1 <= '0;
      wr_m2 <= '0;
    end else begin
      wr_v1 <= dfi_wrdata_en;
      wr_v2 <= wr_v1;
      wr_v3 <= wr_v2;
      wr_d1 <= dfi_wrdata;
      wr_d2 <= wr_d1;
      wr_m1 <= dfi_wrdata_mask;
      wr_m2 <= wr_m1;
    end
  end

  logic                dqs_oe;
  logic                dqs_val;
  logic [DQ_WIDTH-1:0] dq_out;
  logic [NB-1:0]       dm_out;

  // Pre/postamble share the same drive (dqs low), so a preamble following data merges into the postamble.
  assign dqs_oe  = wr_v1 | wr_v2 | wr_v3;
  assign dqs_val = wr_v2 & clk;
  assign dq_out  = clk ? wr_d2[DQ_WIDTH-1:0] : wr_d2[2*DQ_WIDTH-1:DQ_WIDTH];
  assign dm_out  = clk ? wr_m2[NB-1:0] : wr_m2[2*NB-1:NB];

  assign dq      = wr_v2  ? dq_out           : {DQ_WIDTH{1'bz}};
  assign dm_rdqs = wr_v2  ? dm_out           : {NB{1'bz}};
  assign dqs     = dqs_oe ? {NB{dqs_val}}    : {NB{1'bz}};
  assign dqs_n   = dqs_oe ? {NB{~dqs_val}}   : {NB{1'bz}};
  assign rdqs_n  = {NB{1'bz}};

  logic [DQ_WIDTH-1:0] rise_q, fall_q;
  logic [RD_LAT-2:0]   rd_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rise_q <= '0;
    else        rise_q <= dq;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) fall_q <= '0;
    else        fall_q <= dq;
  end

  // The output register is the last of the RD_LAT stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sr            <= '0;
      dfi_rddata_valid <= 1'b0;
      dfi_rddata       <= '0;
    end else begin
      rd_sr[0] <= dfi_rddata_en;
      for (int i = 1; i < RD_LAT - 1; i++) rd_sr[i] <= rd_sr[i-1];
      dfi_rddata_valid <= rd_sr[RD_LAT-2];
      dfi_rddata       <= rd_sr[RD_LAT-2] ? {fall_q, rise_q} : '0;
    end
  end

endmodule

// File: tb/tb_ddr2_dfi_phy.sv
// tb/tb_ddr2_dfi_phy.sv - directed self-checking bench for ddr2_dfi_phy
// Pulls make released pins readable: dq/dqs/dm/rdqs_n float to 1, dqs_n floats to 0.
module tb_ddr2_dfi_phy;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dfi_cke;
  logic [1:0]    dfi_cs_n;
  logic          dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [2:0]    dfi_bank;
  logic [13:0]   dfi_address;
  logic          dfi_odt;
  logic          dfi_wrdata_en;
  logic [127:0]  dfi_wrdata;
  logic [15:0]   dfi_wrdata_mask;
  logic          dfi_rddata_en;
  logic          dfi_rddata_valid;
  logic [127:0]  dfi_rddata;
  logic          ck, ck_n, cke;
  logic [1:0]    cs_n;
  logic          ras_n, cas_n, we_n;
  logic [2:0]    ba;
  logic [13:0]   addr;
  logic          odt;
  wire  [63:0]   dq;
  wire  [7:0]    dqs, dqs_n, dm_rdqs, rdqs_n;

  logic [63:0]   tb_dq;
  logic          tb_dq_oe;
  int            checks;
  int            failures;

  localparam logic [63:0] ZDQ = 64'hFFFF_FFFF_FFFF_FFFF;

  assign dq = tb_dq_oe ? tb_dq : {64{1'bz}};

  for (genvar i = 0; i < 64; i++) begin : g_pu_dq
    pullup (dq[i]);
  end
  for (genvar i = 0; i < 8; i++) begin : g_pull_strobe
    pullup   (dqs[i]);
    pulldown (dqs_n[i]);
    pullup   (dm_rdqs[i]);
    pullup   (rdqs_n[i]);
  end

  always #5 clk = ~clk;

  ddr2_dfi_phy dut (
    .clk(clk), .rst_n(rst_n),
    .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
    .dfi_we_n(dfi_we_n), .dfi_bank(dfi_bank), .dfi_address(dfi_address), .dfi_odt(dfi_odt),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata), .dfi_wrdata_mask(dfi_wrdata_mask),
    .dfi_rddata_en(dfi_rddata_en), .dfi_rddata_valid(dfi_rddata_valid), .dfi_rddata(dfi_rddata),
    .ck(ck), .ck_n(ck_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .odt(odt),
    .dq(dq), .dqs(dqs), .dqs_n(dqs_n), .dm_rdqs(dm_rdqs), .rdqs_n(rdqs_n)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic hi();
    @(posedge clk);
    #2;
  endtask

  task automatic lo();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_idle_bus(input string tag);
    check({tag, "_dq"}, 128'(dq), 128'(ZDQ));
    check({tag, "_dqs"}, 128'(dqs), 128'(8'hFF));
    check({tag, "_dqs_n"}, 128'(dqs_n), 128'(8'h00));
    check({tag, "_dm"}, 128'(dm_rdqs), 128'(8'hFF));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    tb_dq = '0;
    tb_dq_oe = 1'b0;
    rst_n = 1'b0;
    dfi_cke = 1'b1;
    dfi_cs_n = 2'b00;
    dfi_ras_n = 1'b0;
    dfi_cas_n = 1'b0;
    dfi_we_n = 1'b0;
    dfi_bank = 3'd5;
    dfi_address = 14'h2AAA;
    dfi_odt = 1'b1;
    dfi_wrdata_en = 1'b0;
    dfi_wrdata = '0;
    dfi_wrdata_mask = '0;
    dfi_rddata_en = 1'b0;

    repeat (3) hi();
    check("rst_cke", 128'(cke), 128'(1'b0));
    check("rst_cs_n", 128'(cs_n), 128'(2'b11));
    check("rst_ras_cas_we", 128'({ras_n, cas_n, we_n}), 128'(3'b111));
    check("rst_ba", 128'(ba), 128'(3'd0));
    check("rst_addr", 128'(addr), 128'(14'h0));
    check("rst_odt", 128'(odt), 128'(1'b0));
    check("rst_valid", 128'(dfi_rddata_valid), 128'(1'b0));
    check("rst_rddata", dfi_rddata, 128'h0);
    check("rst_rdqs_n", 128'(rdqs_n), 128'(8'hFF));
    chk_idle_bus("rst");

    dfi_cs_n = 2'b11;
    dfi_ras_n = 1'b1;
    dfi_cas_n = 1'b1;
    dfi_we_n = 1'b1;
    dfi_bank = 3'd0;
    dfi_address = 14'h0;
    dfi_odt = 1'b0;
    rst_n = 1'b1;
    hi();
    check("ck_hi", 128'({ck, ck_n}), 128'(2'b10));
    lo();
    check("ck_lo", 128'({ck, ck_n}), 128'(2'b01));

    // Command path: one-cycle registered latency.
    hi();
    dfi_cs_n = 2'b10;
    dfi_ras_n = 1'b0;
    dfi_bank = 3'd3;
    dfi_address = 14'h1234;
    dfi_odt = 1'b1;
    #1;
    check("cmd_not_yet", 128'({cs_n, ras_n}), 128'(3'b111));
    hi();
    check("cmd_cs_n", 128'(cs_n), 128'(2'b10));
    check("cmd_ras_cas_we", 128'({ras_n, cas_n, we_n}), 128'(3'b011));
    check("cmd_ba", 128'(ba), 128'(3'd3));
    check("cmd_addr", 128'(addr), 128'(14'h1234));
    check("cmd_cke_odt", 128'({cke, odt}), 128'(2'b11));
    dfi_cs_n = 2'b11;
    dfi_ras_n = 1'b1;
    dfi_odt = 1'b0;
    hi();
    check("cmd_ras_back", 128'({cs_n, ras_n, odt}), 128'(4'b1110));

    // Single write burst.
    dfi_wrdata_en = 1'b1;
    dfi_wrdata = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    dfi_wrdata_mask = 16'h0000;
    lo();
    chk_idle_bus("w1_n");
    hi();
    dfi_wrdata_en = 1'b0;
    check("w1_pre_dq", 128'(dq), 128'(ZDQ));
    check("w1_pre_dqs", 128'({dqs, dqs_n}), 128'(16'h00FF));
    check("w1_pre_dm", 128'(dm_rdqs), 128'(8'hFF));
    hi();
    check("w1_hi_dq", 128'(dq), 128'(64'h5555_5555_5555_5555));
    check("w1_hi_dqs", 128'({dqs, dqs_n}), 128'(16'hFF00));
    check("w1_hi_dm", 128'(dm_rdqs), 128'(8'h00));
    lo();
    check("w1_lo_dq", 128'(dq), 128'(64'hAAAA_AAAA_AAAA_AAAA));
    check("w1_lo_dqs", 128'({dqs, dqs_n}), 128'(16'h00FF));
    check("w1_lo_dm", 128'(dm_rdqs), 128'(8'h00));
    hi();
    check("w1_post_dq", 128'(dq), 128'(ZDQ));
    check("w1_post_dqs", 128'({dqs, dqs_n}), 128'(16'h00FF));
    hi();
    chk_idle_bus("w1_rel");

    // Back-to-back writes with a non-zero mask on the second beat pair.
    dfi_wrdata_en = 1'b1;
    dfi_wrdata = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    dfi_wrdata_mask = 16'h0000;
    hi();
    dfi_wrdata = {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    dfi_wrdata_mask = 16'hA53C;
    check("w2_pre_dqs", 128'({dqs, dqs_n}), 128'(16'h00FF));
    check("w2_pre_dq", 128'(dq), 128'(ZDQ));
    hi();
    dfi_wrdata_en = 1'b0;
    check("w2_d0_hi", 128'({dq, dqs}), 128'({64'h2222_2222_2222_2222, 8'hFF}));
    lo();
    check("w2_d0_lo", 128'({dq, dqs}), 128'({64'h1111_1111_1111_1111, 8'h00}));
    hi();
    check("w2_d1_hi", 128'({dq, dqs, dm_rdqs}), 128'({64'h4444_4444_4444_4444, 8'hFF, 8'h3C}));
    lo();
    check("w2_d1_lo", 128'({dq, dqs, dqs_n, dm_rdqs}),
          128'({64'h3333_3333_3333_3333, 8'h00, 8'hFF, 8'hA5}));
    hi();
    check("w2_post", 128'({dq, dqs, dqs_n}), 128'({ZDQ, 8'h00, 8'hFF}));
    hi();
    chk_idle_bus("w2_rel");

    // Single read, RD_LAT = 6.
    dfi_rddata_en = 1'b1;
    hi();
    dfi_rddata_en = 1'b0;
    repeat (3) hi();
    lo();
    tb_dq = 64'h0123_4567_0123_4567;
    tb_dq_oe = 1'b1;
    hi();
    check("r1_early_valid", 128'(dfi_rddata_valid), 128'(1'b0));
    tb_dq = 64'h89AB_CDEF_89AB_CDEF;
    hi();
    check("r1_valid", 128'(dfi_rddata_valid), 128'(1'b1));
    check("r1_data", dfi_rddata, {64'h89AB_CDEF_89AB_CDEF, 64'h0123_4567_0123_4567});
    tb_dq_oe = 1'b0;
    hi();
    check("r1_after", 128'({dfi_rddata_valid, dfi_rddata}), 128'h0);

    // Back-to-back reads.
    tb_dq = 64'h0F0F_0F0F_F0F0_F0F0;
    tb_dq_oe = 1'b1;
    dfi_rddata_en = 1'b1;
    hi();
    hi();
    dfi_rddata_en = 1'b0;
    repeat (3) hi();
    check("r2_early", 128'(dfi_rddata_valid), 128'(1'b0));
    hi();
    check("r2_first", 128'({dfi_rddata_valid, dfi_rddata}),
          {1'b1, 64'h0F0F_0F0F_F0F0_F0F0, 64'h0F0F_0F0F_F0F0_F0F0});
    hi();
    check("r2_second", 128'(dfi_rddata_valid), 128'(1'b1));
    hi();
    check("r2_end", 128'(dfi_rddata_valid), 128'(1'b0));
    tb_dq_oe = 1'b0;
    hi();

    // Reset during a data cycle, with a second burst still queued.
    dfi_wrdata_en = 1'b1;
    dfi_wrdata = {64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666};
    hi();
    dfi_wrdata = {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888};
    hi();
    dfi_wrdata_en = 1'b0;
    check("rw_data", 128'(dq), 128'(64'h6666_6666_6666_6666));
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_bus("rw_now");
    hi();
    hi();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      hi();
      check($sformatf("rw_stale_hi%0d", c), 128'({dq, dqs}), 128'({ZDQ, 8'hFF}));
      lo();
      check($sformatf("rw_stale_lo%0d", c), 128'({dq, dqs_n}), 128'({ZDQ, 8'h00}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
